// File: rtl/output_port_arbiter.sv
// Round-robin arbiter for a single router output port.
// It collects one request line from each input port and grants exactly one of them.
// The grant is held until the winner drops its request.
// After that the port stays busy for one extra release cycle before it arbitrates again.
module output_port_arbiter #(
  parameter int N  = 16,
  parameter int SW = $clog2(N),
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  request_in,
  output logic [N-1:0]  grant_out,
  output logic [SW-1:0] sel_out,
  output logic          busy_out,
  output logic [CW-1:0] grant_count_out
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [SW-1:0] sel_q, sel_d;
  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Requests are rotated so that bit 0 is the input the pointer currently favours.
  // The winner is then simply the lowest set bit of the rotated vector.
  logic [SW-1:0] rot_idx [N];
  logic [N-1:0]  req_rot;
  logic [SW-1:0] win_off;
  logic [SW-1:0] winner;
  logic [N-1:0]  win_onehot;
  logic          any_req;

  // The index arithmetic is SW bits wide, so it wraps modulo N for free (N is a power of two).
  for (genvar gi = 0; gi < N; gi++) begin : g_rotate
    assign rot_idx[gi] = ptr_q + SW'(gi);
    assign req_rot[gi] = request_in[rot_idx[gi]];
  end

  // Lowest set bit of the rotated request gives the winner's distance from the pointer.
  always_comb begin
    win_off = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_rot[k]) win_off = SW'(k);
    end
  end

  assign winner  = ptr_q + win_off;
  assign any_req = |request_in;

  for (genvar gi = 0; gi < N; gi++) begin : g_onehot
    assign win_onehot[gi] = (winner == SW'(gi));
  end

  // Next-state and registered-output logic for the IDLE/GRANT/RELEASE sequence.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        grant_d = '0;
        busy_d  = 1'b0;
        if (any_req) begin
          state_d = S_GRANT;
          grant_d = win_onehot;
          sel_d   = winner;
          busy_d  = 1'b1;
          ptr_d   = winner + SW'(1);
          cnt_d   = cnt_q + CW'(1);
        end
      end
      S_GRANT: begin
        // No preemption: only the current owner's request line matters here.
        if (!request_in[sel_q]) begin
          state_d = S_RELEASE;
          grant_d = '0;
        end
      end
      S_RELEASE: begin
        // One dead cycle; requests are not looked at until IDLE.
        state_d = S_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        ptr_d   = '0;
        grant_d = '0;
        sel_d   = '0;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers; reset clears everything immediately, even mid-grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant_out       = grant_q;
  assign sel_out         = sel_q;
  assign busy_out        = busy_q;
  assign grant_count_out = cnt_q;

endmodule

// File: tb/tb_output_port_arbiter.sv
// Directed bench for output_port_arbiter.
// It uses a 16-bit-counter instance for the main scenarios.
// A second instance with a 4-bit counter checks that the grant count wraps.
module tb_output_port_arbiter;

  logic        clk;
  logic        reset;
  logic [15:0] req;
  logic [15:0] grant;
  logic [3:0]  sel;
  logic        busy;
  logic [15:0] cnt;

  logic [15:0] req4;
  logic [15:0] grant4;
  logic [3:0]  sel4;
  logic        busy4;
  logic [3:0]  cnt4;

  int checks   = 0;
  int failures = 0;

  output_port_arbiter #(.N(16), .CW(16)) dut (
    .clk(clk), .reset(reset), .request_in(req),
    .grant_out(grant), .sel_out(sel), .busy_out(busy), .grant_count_out(cnt)
  );

  output_port_arbiter #(.N(16), .CW(4)) dut4 (
    .clk(clk), .reset(reset), .request_in(req4),
    .grant_out(grant4), .sel_out(sel4), .busy_out(busy4), .grant_count_out(cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] req;
    logic [15:0] grant;
    logic [3:0]  sel;
    logic        busy;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [15:0] r, logic [15:0] g, logic [3:0] s, logic b, logic [15:0] c);
    vec_t v;
    v.req = r; v.grant = g; v.sel = s; v.busy = b; v.cnt = c;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int zeros;
    bit got;
    int bit_i;

    reset = 1'b1;
    req   = '0;
    req4  = '0;

    // Single requester on input 3, held 5 cycles; ptr ends at 4.
    repeat (5) tbl.push_back(mk(16'h0008, 16'h0008, 4'd3, 1'b1, 16'd1));
    tbl.push_back(mk(16'h0000, 16'h0000, 4'd3, 1'b1, 16'd1));
    tbl.push_back(mk(16'h0000, 16'h0000, 4'd3, 1'b0, 16'd1));
    tbl.push_back(mk(16'h0000, 16'h0000, 4'd3, 1'b0, 16'd1));
    // Input 5 granted, input 2 raises mid-grant: no preemption; ptr 6 after.
    tbl.push_back(mk(16'h0020, 16'h0020, 4'd5, 1'b1, 16'd2));
    tbl.push_back(mk(16'h0024, 16'h0020, 4'd5, 1'b1, 16'd2));
    tbl.push_back(mk(16'h0024, 16'h0020, 4'd5, 1'b1, 16'd2));
    tbl.push_back(mk(16'h0004, 16'h0000, 4'd5, 1'b1, 16'd2));
    tbl.push_back(mk(16'h0004, 16'h0000, 4'd5, 1'b0, 16'd2));
    tbl.push_back(mk(16'h0004, 16'h0004, 4'd2, 1'b1, 16'd3));
    tbl.push_back(mk(16'h0000, 16'h0000, 4'd2, 1'b1, 16'd3));
    tbl.push_back(mk(16'h0000, 16'h0000, 4'd2, 1'b0, 16'd3));
    // ptr=3, inputs 1 and 6 request: 6 wins, then 1.
    tbl.push_back(mk(16'h0042, 16'h0040, 4'd6, 1'b1, 16'd4));
    tbl.push_back(mk(16'h0002, 16'h0000, 4'd6, 1'b1, 16'd4));
    tbl.push_back(mk(16'h0002, 16'h0000, 4'd6, 1'b0, 16'd4));
    tbl.push_back(mk(16'h0002, 16'h0002, 4'd1, 1'b1, 16'd5));
    tbl.push_back(mk(16'h0000, 16'h0000, 4'd1, 1'b1, 16'd5));
    tbl.push_back(mk(16'h0000, 16'h0000, 4'd1, 1'b0, 16'd5));
    // Pointer wrap: 15 granted sets ptr=0, so 0x8001 grants 0 then 15.
    tbl.push_back(mk(16'h8000, 16'h8000, 4'd15, 1'b1, 16'd6));
    tbl.push_back(mk(16'h0000, 16'h0000, 4'd15, 1'b1, 16'd6));
    tbl.push_back(mk(16'h0000, 16'h0000, 4'd15, 1'b0, 16'd6));
    tbl.push_back(mk(16'h8001, 16'h0001, 4'd0, 1'b1, 16'd7));
    tbl.push_back(mk(16'h8000, 16'h0000, 4'd0, 1'b1, 16'd7));
    tbl.push_back(mk(16'h8000, 16'h0000, 4'd0, 1'b0, 16'd7));
    tbl.push_back(mk(16'h8000, 16'h8000, 4'd15, 1'b1, 16'd8));
    tbl.push_back(mk(16'h0000, 16'h0000, 4'd15, 1'b1, 16'd8));
    tbl.push_back(mk(16'h0000, 16'h0000, 4'd15, 1'b0, 16'd8));

    // Reset state, held across a couple of edges.
    repeat (2) tick();
    check("reset_grant", 32'(grant), 32'h0);
    check("reset_sel",   32'(sel),   32'h0);
    check("reset_busy",  32'(busy),  32'h0);
    check("reset_cnt",   32'(cnt),   32'h0);
    check("reset_cnt4",  32'(cnt4),  32'h0);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      req = tbl[i].req;
      tick();
      $display("vec %0d req=%h grant=%h sel=%0d busy=%0b cnt=%0d", i, req, grant, sel, busy, cnt);
      check($sformatf("vec%0d_grant", i), 32'(grant), 32'(tbl[i].grant));
      check($sformatf("vec%0d_sel", i),   32'(sel),   32'(tbl[i].sel));
      check($sformatf("vec%0d_busy", i),  32'(busy),  32'(tbl[i].busy));
      check($sformatf("vec%0d_cnt", i),   32'(cnt),   32'(tbl[i].cnt));
    end

    // All requesting: order 0..15,0 with exactly 2 idle grant cycles between grants.
    req   = 16'hFFFF;
    zeros = 0;
    for (int g = 0; g < 17; g++) begin
      bit_i = g % 16;
      got   = 1'b0;
      for (int t = 0; t < 8 && !got; t++) begin
        tick();
        if (grant != 16'h0) got = 1'b1;
        else zeros++;
      end
      if (!got) begin
        failures++;
        $display("FAIL allreq_timeout: got no grant expected grant %0d", bit_i);
      end
      $display("allreq grant %0d grant=%h zeros=%0d", g, grant, zeros);
      check($sformatf("allreq%0d_grant", g), 32'(grant), 32'(16'h1 << bit_i));
      if (g > 0) check($sformatf("allreq%0d_gap", g), 32'(zeros), 32'd2);
      repeat (2) tick();
      check($sformatf("allreq%0d_hold", g), 32'(grant), 32'(16'h1 << bit_i));
      req[bit_i] = 1'b0;
      tick();
      check($sformatf("allreq%0d_rel", g), 32'(grant), 32'h0);
      zeros = 1;
      req   = (g == 16) ? 16'h0000 : 16'hFFFF;
    end
    check("allreq_cnt", 32'(cnt), 32'd25);
    tick();
    check("allreq_idle_busy", 32'(busy), 32'h0);

    // Asynchronous reset in the middle of a grant to input 8.
    req = 16'h0100;
    tick();
    $display("async pre grant=%h busy=%0b", grant, busy);
    check("async_pre_grant", 32'(grant), 32'h0100);
    check("async_pre_busy",  32'(busy),  32'h1);
    #2 reset = 1'b1;
    #1;
    $display("async during grant=%h busy=%0b sel=%0d cnt=%0d", grant, busy, sel, cnt);
    check("async_grant", 32'(grant), 32'h0);
    check("async_busy",  32'(busy),  32'h0);
    check("async_sel",   32'(sel),   32'h0);
    check("async_cnt",   32'(cnt),   32'h0);
    #2 reset = 1'b0;
    req = 16'h0300;
    tick();
    $display("async post grant=%h sel=%0d cnt=%0d", grant, sel, cnt);
    check("async_post_grant", 32'(grant), 32'h0100);
    check("async_post_sel",   32'(sel),   32'd8);
    check("async_post_cnt",   32'(cnt),   32'd1);
    req = 16'h0000;

    // Counter wrap on the 4-bit instance: 17 grants leave the count at 1.
    for (int k = 0; k < 17; k++) begin
      req4 = 16'h0001;
      tick();
      check($sformatf("wrap%0d_grant", k), 32'(grant4), 32'h1);
      check($sformatf("wrap%0d_cnt", k), 32'(cnt4), 32'((k + 1) % 16));
      req4 = 16'h0000;
      repeat (2) begin
        tick();
        check($sformatf("wrap%0d_onehot", k), 32'($countones(grant4) <= 1), 32'h1);
      end
    end
    $display("wrap final cnt4=%0d", cnt4);
    check("wrap_final_cnt", 32'(cnt4), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
